// File: rtl/button_event_gen_pkg.sv
// Shared types for the button event generator: FSM state encoding and strobe bundle.
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  typedef struct packed {
    logic press;
    logic rel;
    logic long_hit;
    logic rpt;
  } strobes_t;

endpackage

// File: rtl/button_event_gen_timer.sv
// Hold/repeat interval counter with synchronous clear, count enable and terminal compare.
module button_event_gen_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/long-press/auto-repeat strobes,
// a held level and a wrapping press counter. All outputs are registered.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_level,
  input  logic             repeat_en,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_press,
  output logic             repeat_pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_TICKS - 1);

  state_t           state, nxt;
  strobes_t         stb;
  logic             clr, en, hit;
  logic [CNT_W-1:0] term;

  button_event_gen_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .term  (term),
    .hit   (hit)
  );

  always_comb begin
    nxt  = state;
    stb  = '0;
    clr  = 1'b0;
    en   = 1'b0;
    term = (state == ST_LONG) ? REP_TERM : HOLD_TERM;
    case (state)
      ST_IDLE: begin
        if (btn_level) begin
          nxt       = ST_PRESSED;
          stb.press = 1'b1;
          clr       = 1'b1;
        end
      end
      ST_PRESSED: begin
        // release has priority over the hold threshold
        if (!btn_level) begin
          nxt     = ST_IDLE;
          stb.rel = 1'b1;
          clr     = 1'b1;
        end else if (hit) begin
          nxt          = ST_LONG;
          stb.long_hit = 1'b1;
          clr          = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      ST_LONG: begin
        if (!btn_level) begin
          nxt     = ST_IDLE;
          stb.rel = 1'b1;
          clr     = 1'b1;
        end else if (repeat_en && hit) begin
          stb.rpt = 1'b1;
          clr     = 1'b1;
        end else if (repeat_en) begin
          en = 1'b1;
        end else begin
          clr = 1'b1;
        end
      end
      default: begin
        nxt = ST_IDLE;
        clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= nxt;
      press_pulse   <= stb.press;
      release_pulse <= stb.rel;
      long_press    <= stb.long_hit;
      repeat_pulse  <= stb.rpt;
      held          <= (nxt != ST_IDLE);
      if (stb.press) press_count <= press_count + 1'b1;
    end
  end

endmodule
